req_priority_arbiter: RTL and testbench



---
 rtl/req_priority_arbiter.sv | 159 +++++++++++++++
 tb/tb_req_priority_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_priority_arbiter.sv
// req_priority_arbiter
// ---------------------------------------------------------------------------
// Registered 8-requester arbiter for a shared resource. Two arbitration modes:
// fixed priority (bit 7 highest, the usual 8:3 priority encode) and
// round-robin (search downward starting just below the last winner). An owner
// keeps the grant until it drops its request or, with others waiting, until
// the hold timeout expires. There is no pre-emption.
//
// Handshake: req[i] is a level request; the grant is a registered one-hot gnt
// appearing one cycle after the request is arbitrated. A requester owns the
// resource for every cycle gnt[i]=1 and releases it by dropping req[i];
// gnt_valid is simply "some gnt bit is set".
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   req        request vector, bit i = requester i
//   mode       0 = fixed priority (7 highest), 1 = round-robin
//   gnt        one-hot grant (registered)
//   gnt_idx    encoded index of the granted requester (registered, holds its
//              last value while gnt_valid=0)
//   gnt_valid  high when gnt is non-zero (registered)
//   state_dbg  FSM state for observation: 0 = IDLE, 1 = GRANT
// ---------------------------------------------------------------------------
module req_priority_arbiter #(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             mode,
  output logic [N_REQ-1:0] gnt,
  output logic [2:0]       gnt_idx,
  output logic             gnt_valid,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = TIMEOUT_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [2:0]       last_idx;

  // Highest set bit wins.
  function automatic logic [2:0] pe8(input logic [N_REQ-1:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Candidates: the current owner is always masked. In IDLE gnt is zero, so
  // this is plain req; on release req[owner] is already zero; on timeout the
  // mask is what lets the others win.
  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] rot;
  logic [2:0]       shift;
  logic [2:0]       src;
  logic [2:0]       rot_idx;
  logic [2:0]       win_idx;
  logic             win_found;

  // Round-robin is a rotation followed by the fixed encoder: rot[j] holds
  // cand[(j + last_idx) mod 8], so rot[7] is requester last_idx-1, the first
  // one searched. Fixed mode is the same path with no rotation.
  always_comb begin
    cand  = req & ~gnt;
    shift = mode ? last_idx : 3'd0;
    rot   = '0;
    src   = 3'd0;
    for (int j = 0; j < N_REQ; j++) begin
      src    = 3'(j) + shift;
      rot[j] = cand[src];
    end
    rot_idx   = pe8(rot);
    win_idx   = rot_idx + shift;
    win_found = |cand;
  end

  logic owner_req;
  logic timeout;

  assign owner_req = req[gnt_idx];
  assign timeout   = TIMEOUT_EN && (hold_cnt == HOLD_LAST);

  // Next-action decode for the state register below.
  logic take_grant;
  logic go_idle;
  logic clr_cnt;
  logic inc_cnt;

  always_comb begin
    take_grant = 1'b0;
    go_idle    = 1'b0;
    clr_cnt    = 1'b0;
    inc_cnt    = 1'b0;
    case (state)
      IDLE: begin
        take_grant = win_found;
      end
      GRANT: begin
        if (!owner_req) begin
          if (win_found) take_grant = 1'b1;
          else           go_idle    = 1'b1;
        end else if (timeout) begin
          // Lone owner past its hold limit simply starts a new hold period.
          if (win_found) take_grant = 1'b1;
          else           clr_cnt    = 1'b1;
        end else if (TIMEOUT_EN) begin
          inc_cnt = 1'b1;
        end
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_idx   <= 3'd0;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
      last_idx  <= 3'd0;
    end else if (take_grant) begin
      state     <= GRANT;
      gnt       <= N_REQ'(1) << win_idx;
      gnt_idx   <= win_idx;
      gnt_valid <= 1'b1;
      hold_cnt  <= '0;
      last_idx  <= win_idx;
    end else if (go_idle) begin
      // gnt_idx deliberately keeps the previous owner.
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
    end else if (clr_cnt) begin
      hold_cnt  <= '0;
    end else if (inc_cnt) begin
      hold_cnt  <= hold_cnt + CNT_W'(1);
    end
  end

  assign state_dbg = (state == GRANT);

endmodule

// File: tb/tb_req_priority_arbiter.sv
// Testbench for req_priority_arbiter (instantiated with MAX_HOLD=4).
// A cycle model predicts {state, gnt_valid, gnt_idx, gnt} for every driven
// cycle and pushes it to exp_q; the DUT result is popped and compared 1 ns
// after the rising edge. Each scenario task also makes its own directed checks.
module tb_req_priority_arbiter;

  localparam int W       = 13;
  localparam int TB_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       mode;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       state_dbg;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  // Reference model state
  logic       m_busy;
  logic [7:0] m_gnt;
  logic [2:0] m_idx;
  int         m_cnt;
  logic [2:0] m_last;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  req_priority_arbiter #(
    .N_REQ   (8),
    .MAX_HOLD(TB_HOLD),
    .CNT_W   (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .mode     (mode),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .state_dbg(state_dbg)
  );

  // ---------------- model ----------------
  function automatic void model_reset();
    m_busy = 1'b0;
    m_gnt  = 8'h00;
    m_idx  = 3'd0;
    m_cnt  = 0;
    m_last = 3'd0;
    exp_q.delete();
  endfunction

  function automatic void model_arb(input logic [7:0] c, input logic md,
                                    input logic [2:0] last,
                                    output logic found, output logic [2:0] w);
    int i;
    found = 1'b0;
    w     = 3'd0;
    if (!md) begin
      for (int k = 7; k >= 0; k--) begin
        if (!found && c[k]) begin
          found = 1'b1;
          w     = 3'(k);
        end
      end
    end else begin
      for (int k = 1; k <= 8; k++) begin
        i = (int'(last) - k + 8) % 8;
        if (!found && c[i]) begin
          found = 1'b1;
          w     = 3'(i);
        end
      end
    end
  endfunction

  function automatic void model_grant(input logic [2:0] w);
    m_busy = 1'b1;
    m_gnt  = 8'h00;
    m_gnt[w] = 1'b1;
    m_idx  = w;
    m_cnt  = 0;
    m_last = w;
  endfunction

  function automatic void model_step(input logic [7:0] r, input logic md);
    logic [7:0] c;
    logic       found;
    logic [2:0] w;
    c = m_busy ? (r & ~m_gnt) : r;
    model_arb(c, md, m_last, found, w);
    if (!m_busy) begin
      if (found) model_grant(w);
    end else if (!r[m_idx]) begin
      if (found) model_grant(w);
      else begin
        m_busy = 1'b0;
        m_gnt  = 8'h00;
        m_cnt  = 0;
      end
    end else if (m_cnt == TB_HOLD - 1) begin
      if (found) model_grant(w);
      else m_cnt = 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
    exp_q.push_back({m_busy, |m_gnt, m_idx, m_gnt});
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive, predict, then compare after the rise.
  task automatic drive_and_check(input logic [7:0] r, input logic md);
    logic [W-1:0] e;
    logic [W-1:0] got;
    req  = r;
    mode = md;
    model_step(r, md);
    @(posedge clk);
    #1;
    got = {state_dbg, gnt_valid, gnt_idx, gnt};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got %h req %h", got, r);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t req=%h mode=%0d got %h exp %h", $time, r, md, got, e);
      end
    end
  endtask

  task automatic cycle(input logic [7:0] r, input logic md);
    @(negedge clk);
    drive_and_check(r, md);
  endtask

  // Async reset mid-cycle; checks outputs clear before any clock edge, then
  // releases reset at a falling edge (caller drives from that same time).
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({state_dbg, gnt_valid, gnt_idx, gnt} !== 13'h0) begin
      errors++;
      $display("FAIL async_reset got st=%0d v=%0d idx=%0d gnt=%h exp all 0",
               state_dbg, gnt_valid, gnt_idx, gnt);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cycle(8'hFF, 1'b0);
    cycle(8'hFF, 1'b0);
    checks++;
    if (gnt_idx !== 3'd7) begin
      errors++;
      $display("FAIL pre_reset_owner got %0d exp 7", gnt_idx);
    end
    do_reset();
    drive_and_check(8'hFF, 1'b0);
    checks++;
    if (gnt !== 8'h80 || gnt_idx !== 3'd7) begin
      errors++;
      $display("FAIL post_reset_grant got gnt=%h idx=%0d exp 80/7", gnt, gnt_idx);
    end
  endtask

  task automatic test_fixed_release();
    cycle(8'h2C, 1'b0);
    checks++;
    if (gnt_idx !== 3'd5 || gnt !== 8'h20) begin
      errors++;
      $display("FAIL fixed_first got gnt=%h idx=%0d exp 20/5", gnt, gnt_idx);
    end
    cycle(8'h0C, 1'b0);
    checks++;
    if (gnt_idx !== 3'd3 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL fixed_release5 got idx=%0d v=%0d exp 3/1", gnt_idx, gnt_valid);
    end
    cycle(8'h04, 1'b0);
    checks++;
    if (gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL fixed_release3 got idx=%0d v=%0d exp 2/1", gnt_idx, gnt_valid);
    end
    cycle(8'h00, 1'b0);
    checks++;
    if (gnt_valid !== 1'b0 || gnt !== 8'h00 || gnt_idx !== 3'd2) begin
      errors++;
      $display("FAIL fixed_idle got v=%0d gnt=%h idx=%0d exp 0/00/2", gnt_valid, gnt, gnt_idx);
    end
  endtask

  task automatic test_rr_rotation();
    logic [2:0] rr_exp[4];
    rr_exp[0] = 3'd7;
    rr_exp[1] = 3'd4;
    rr_exp[2] = 3'd0;
    rr_exp[3] = 3'd7;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (k == 0) drive_and_check(8'h91, 1'b1);
      else cycle(8'h91, 1'b1);
      checks++;
      if (gnt_idx !== rr_exp[k/4] || gnt_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_rotation cycle %0d got idx=%0d v=%0d exp %0d/1", k, gnt_idx, gnt_valid, rr_exp[k/4]);
      end
    end
  endtask

  task automatic test_lone_timeout();
    cycle(8'h00, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cycle(8'h08, 1'b1);
      checks++;
      if (gnt_idx !== 3'd3 || gnt_valid !== 1'b1) begin
        errors++;
        $display("FAIL lone_timeout cycle %0d got idx=%0d v=%0d exp 3/1", k, gnt_idx, gnt_valid);
      end
    end
  endtask

  task automatic test_no_preempt();
    logic md_seq[3];
    md_seq[0] = 1'b0;
    md_seq[1] = 1'b1;
    md_seq[2] = 1'b0;
    cycle(8'h00, 1'b0);
    cycle(8'h02, 1'b0);
    checks++;
    if (gnt_idx !== 3'd1) begin
      errors++;
      $display("FAIL preempt_owner got %0d exp 1", gnt_idx);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(8'h42, md_seq[k]);
      checks++;
      if (gnt !== 8'h02) begin
        errors++;
        $display("FAIL no_preempt cycle %0d got gnt=%h exp 02", k, gnt);
      end
    end
    cycle(8'h40, 1'b0);
    checks++;
    if (gnt_idx !== 3'd6 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL preempt_handover got idx=%0d v=%0d exp 6/1", gnt_idx, gnt_valid);
    end
  endtask

  task automatic test_simultaneous();
    cycle(8'h00, 1'b0);
    cycle(8'h10, 1'b0);
    checks++;
    if (gnt_idx !== 3'd4) begin
      errors++;
      $display("FAIL simul_owner got %0d exp 4", gnt_idx);
    end
    cycle(8'h04, 1'b0);
    checks++;
    if (gnt_idx !== 3'd2 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul_handover got idx=%0d v=%0d exp 2/1", gnt_idx, gnt_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r;
    for (int k = 0; k < 80; k++) begin
      r = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
      cycle(r, 1'($urandom_range(0, 1)));
    end
  endtask

  // ---------------- main ----------------
  initial begin
    rst  = 1'b1;
    req  = 8'h00;
    mode = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_fixed_release();
    test_rr_rotation();
    test_lone_timeout();
    test_no_preempt();
    test_simultaneous();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
